issue_y: RTL and testbench
==========================

# issue_y

Issue-side driver for the Execute_Y multiply pipeline. It accepts decoded multiply instructions over a valid/ready handshake and reads source operands from the register file. It tracks in-flight destinations against Execute_Y's fixed latency, stalls on read-after-write hazards, and forwards the Y writeback value. It produces the `is_y_*` bundle consumed by Execute_Y, including the bubble code whenever nothing issues.

## Interface
- `Y_LATENCY`, default 4: edges from `is_y_*` registered to `y_wb_*` valid (Y0..Y3).
- `clock` in 1: single clock.
- `reset` in 1: reset is asynchronous and active-high.
- `dc_is_valid` in 1: decode presents a multiply instruction.
- `dc_is_ready` out 1: combinational; instruction accepted on an edge with valid && ready.
- `dc_is_rs`, `dc_is_rt`, `dc_is_rd` in 5 each: source A, source B, destination register numbers.
- `is_rf_addra`, `is_rf_addrb` out 5 each: equal `dc_is_rs` and `dc_is_rt`, combinational.
- `rf_is_dataa`, `rf_is_datab` in 32 each: combinational register file read data.
- `y_wb_regdest` in 5, `y_wb_writereg` in 1, `y_wb_wbvalue` in 32: Execute_Y writeback, used for forwarding.
- `is_y_functionalunit` out 2: `FU_Y` (3) = issue; `FU_NONE` (0) = bubble.
- `is_y_rega`, `is_y_regb` out 32 each: operands.
- `is_y_regdest` out 5: destination register.

## Operation
- **Tracker.**
  - Shift register t[0..Y_LATENCY], each entry {valid, regdest}.
  - On every edge t[k+1] <= t[k].
  - t[0] <= {issue, dc_is_rd} in the same edge that registers `is_y_*`.
  - t[Y_LATENCY] always describes the instruction currently on `y_wb_*`.
- **Hazard.**
  - A source s (rs or rt) is blocked if s != 0 and any valid t[k] with k in 0..Y_LATENCY-1 has regdest == s.
  - `dc_is_ready` = !(hazard_rs || hazard_rt). It does not depend on `dc_is_valid`.
- **Operand select, per source.**
  - s == 0 → 0.
  - Else if valid t[Y_LATENCY], regdest == s and `y_wb_writereg` → `y_wb_wbvalue`.
  - Else the register file data.
  - When `y_wb_writereg`=0 (Y overflow), the register is not written, so the register file value is the correct operand.
- **Issue edge (valid && ready).**
  - `is_y_functionalunit` <= 3.
  - `is_y_rega`/`is_y_regb` <= selected operands.
  - `is_y_regdest` <= rd.
- **No issue.**
  - `is_y_functionalunit` <= 0.
  - `is_y_rega`, `is_y_regb`, `is_y_regdest` <= 0.
  - t[0].valid <= 0.
- **rd == 0.** Issues normally; the tracker entry is stored but never blocks, because source 0 never hazards.
- **WAW.** Needs no check. The pipe is fixed-latency and in-order, and the youngest matching entry is the one that gates.
- **Multiple matches.** Hazard is the OR over all entries; the forward uses only t[Y_LATENCY].

## Timing
- **Reset values** (asynchronous, while `reset`=1): every t entry invalid; `is_y_functionalunit`=0, `is_y_rega`=0, `is_y_regb`=0, `is_y_regdest`=0.
  - `dc_is_ready`=1 during and after reset, since the tracker is empty.
- **Reset mid-operation:** all tracking is discarded. Execute_Y is reset by the same system reset, so no stale writeback is expected afterwards.
- **Issue latency:** `is_y_*` are valid the cycle after the handshake edge. The result appears on `y_wb_*` Y_LATENCY cycles after that.
- **Back-to-back independent instructions:** one per cycle, no bubbles.
- **Dependent instruction presented the cycle after its producer:**
  - `dc_is_ready`=0 for exactly Y_LATENCY cycles (4).
  - It issues in the cycle the producer sits on `y_wb_*`, with the operand forwarded.
- **Register file write-through:** the register file commits `y_wb_*` on the edge after the value is shown. From then on the producer has left the tracker and the register file read is current.

## Structure
- Package `y_pkg`:
  - `FU_Y`=2'd3, `FU_NONE`=2'd0.
  - `Y_LATENCY_DEFAULT`=4.
  - typedef `y_track_t` {logic valid; logic [4:0] regdest}.
- Sub-module `y_tracker`:
  - Holds the shift register.
  - Outputs `busy_a`/`busy_b` (hazard) and `fwd_a`/`fwd_b` (tail match).
  - Inputs: `push`, `push_rd`, `rs`, `rt`.
- Top level `issue_y`: handshake, operand muxes, output registers.

## Test plan
- **Reset:** assert `reset` with `dc_is_valid`=0 → all `is_y_*`=0, `dc_is_ready`=1; hold 10 cycles → `is_y_functionalunit` stays 0.
- **Single issue:** r1=6, r2=7; issue rs=1, rt=2, rd=3 → next cycle fu=3, rega=6, regb=7, regdest=3. Following cycle fu=0, operands and regdest 0.
- **RAW forward:** issue r3=r1*r2, then present rs=3, rt=1 → ready=0 for 4 cycles. It issues in the cycle `y_wb_regdest`=3, `y_wb_wbvalue`=42 → `is_y_rega`=42, `is_y_regb`=6.
- **Overflow forward:** same sequence but `y_wb_writereg`=0 and register file r3=99 → `is_y_rega`=99.
- **Register zero:** rs=0 while tracker entries hold regdest 0 → no stall, `is_y_rega`=0 despite `rf_is_dataa`=0xDEADBEEF.
- **Reset mid-stream:** issue 3 dependent instructions, assert `reset` while one is stalled → outputs 0 immediately, ready=1 after release, tracker empty.

Source files
------------

// File: rtl/y_pkg.sv
// Shared constants, tracker entry type and operand-select helper for the Y issue stage.
package y_pkg;

  localparam logic [1:0] FU_Y    = 2'd3;
  localparam logic [1:0] FU_NONE = 2'd0;

  localparam int Y_LATENCY_DEFAULT = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] regdest;
  } y_track_t;

  // Register 0 reads as zero; otherwise the Y writeback wins over the register file.
  function automatic logic [31:0] pick_operand(
    input logic [4:0]  src,
    input logic        use_fwd,
    input logic [31:0] wb_value,
    input logic [31:0] rf_value
  );
    if (src == 5'd0) begin
      return 32'd0;
    end
    if (use_fwd) begin
      return wb_value;
    end
    return rf_value;
  endfunction

endpackage

// File: rtl/y_tracker.sv
// In-flight destination tracker for Execute_Y: one entry per pipeline edge, tail entry
// describes the instruction currently on the writeback bus.
module y_tracker
  import y_pkg::*;
#(
  parameter int Y_LATENCY = Y_LATENCY_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [4:0] push_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       busy_a,
  output logic       busy_b,
  output logic       fwd_a,
  output logic       fwd_b
);

  y_track_t [Y_LATENCY:0] t_q;
  y_track_t [Y_LATENCY:0] t_d;

  always_comb begin
    t_d            = t_q;
    t_d[0].valid   = push;
    t_d[0].regdest = push_rd;
    for (int k = 0; k < Y_LATENCY; k++) begin
      t_d[k+1] = t_q[k];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  // Source 0 never blocks, which also makes rd == 0 entries harmless.
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int k = 0; k < Y_LATENCY; k++) begin
      if (t_q[k].valid && (t_q[k].regdest == rs) && (rs != 5'd0)) begin
        busy_a = 1'b1;
      end
      if (t_q[k].valid && (t_q[k].regdest == rt) && (rt != 5'd0)) begin
        busy_b = 1'b1;
      end
    end
  end

  assign fwd_a = t_q[Y_LATENCY].valid && (t_q[Y_LATENCY].regdest == rs) && (rs != 5'd0);
  assign fwd_b = t_q[Y_LATENCY].valid && (t_q[Y_LATENCY].regdest == rt) && (rt != 5'd0);

endmodule

// File: rtl/issue_y.sv
// Issue stage for the Execute_Y multiply pipe: handshake with decode, RAW stall,
// writeback forwarding and the registered is_y_* bundle.
module issue_y
  import y_pkg::*;
#(
  parameter int Y_LATENCY = Y_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dc_is_valid,
  output logic        dc_is_ready,
  input  logic [4:0]  dc_is_rs,
  input  logic [4:0]  dc_is_rt,
  input  logic [4:0]  dc_is_rd,
  output logic [4:0]  is_rf_addra,
  output logic [4:0]  is_rf_addrb,
  input  logic [31:0] rf_is_dataa,
  input  logic [31:0] rf_is_datab,
  input  logic [4:0]  y_wb_regdest,
  input  logic        y_wb_writereg,
  input  logic [31:0] y_wb_wbvalue,
  output logic [1:0]  is_y_functionalunit,
  output logic [31:0] is_y_rega,
  output logic [31:0] is_y_regb,
  output logic [4:0]  is_y_regdest
);

  logic        busy_a, busy_b, fwd_a, fwd_b;
  logic        issue;
  logic        use_fwd_a, use_fwd_b;
  logic [1:0]  fu_q, fu_d;
  logic [31:0] rega_q, rega_d;
  logic [31:0] regb_q, regb_d;
  logic [4:0]  rd_q, rd_d;

  assign is_rf_addra = dc_is_rs;
  assign is_rf_addrb = dc_is_rt;

  // Handshake: an instruction moves on every edge where dc_is_valid && dc_is_ready.
  // Ready is a pure hazard verdict on the presented sources and never looks at valid;
  // decode must hold rs/rt/rd stable while valid is high and ready is low.
  assign dc_is_ready = !(busy_a || busy_b);
  assign issue       = dc_is_valid && dc_is_ready;

  y_tracker #(
    .Y_LATENCY(Y_LATENCY)
  ) u_tracker (
    .clock  (clock),
    .reset  (reset),
    .push   (issue),
    .push_rd(dc_is_rd),
    .rs     (dc_is_rs),
    .rt     (dc_is_rt),
    .busy_a (busy_a),
    .busy_b (busy_b),
    .fwd_a  (fwd_a),
    .fwd_b  (fwd_b)
  );

  // The bus regdest must agree with the tracker tail; an overflowed result is not
  // written, so the register file copy stays the right operand.
  assign use_fwd_a = fwd_a && y_wb_writereg && (y_wb_regdest == dc_is_rs);
  assign use_fwd_b = fwd_b && y_wb_writereg && (y_wb_regdest == dc_is_rt);

  always_comb begin
    fu_d   = FU_NONE;
    rega_d = 32'd0;
    regb_d = 32'd0;
    rd_d   = 5'd0;
    if (issue) begin
      fu_d   = FU_Y;
      rega_d = pick_operand(dc_is_rs, use_fwd_a, y_wb_wbvalue, rf_is_dataa);
      regb_d = pick_operand(dc_is_rt, use_fwd_b, y_wb_wbvalue, rf_is_datab);
      rd_d   = dc_is_rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fu_q   <= FU_NONE;
      rega_q <= 32'd0;
      regb_q <= 32'd0;
      rd_q   <= 5'd0;
    end else begin
      fu_q   <= fu_d;
      rega_q <= rega_d;
      regb_q <= regb_d;
      rd_q   <= rd_d;
    end
  end

  assign is_y_functionalunit = fu_q;
  assign is_y_rega           = rega_q;
  assign is_y_regb           = regb_q;
  assign is_y_regdest        = rd_q;

endmodule

// File: tb/tb_issue_y.sv
// Bench for issue_y: a register file and Execute_Y model around the DUT, directed
// scenarios followed by random traffic, all outputs checked through an expected queue.
module tb_issue_y;

  localparam int L = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        dc_is_valid;
  logic        dc_is_ready;
  logic [4:0]  dc_is_rs, dc_is_rt, dc_is_rd;
  logic [4:0]  is_rf_addra, is_rf_addrb;
  logic [31:0] rf_is_dataa, rf_is_datab;
  logic [4:0]  y_wb_regdest;
  logic        y_wb_writereg;
  logic [31:0] y_wb_wbvalue;
  logic [1:0]  is_y_functionalunit;
  logic [31:0] is_y_rega, is_y_regb;
  logic [4:0]  is_y_regdest;

  logic [31:0] rf [32];
  logic        st_v   [L+1];
  logic [4:0]  st_rd  [L+1];
  logic [31:0] st_val [L+1];
  logic        st_wr  [L+1];
  int          wr_mode;

  logic [68:0] exp_q[$];
  logic [68:0] e;
  int          checks = 0;
  int          errors = 0;
  int          stalls;

  issue_y #(.Y_LATENCY(L)) dut (
    .clock              (clock),
    .reset              (reset),
    .dc_is_valid        (dc_is_valid),
    .dc_is_ready        (dc_is_ready),
    .dc_is_rs           (dc_is_rs),
    .dc_is_rt           (dc_is_rt),
    .dc_is_rd           (dc_is_rd),
    .is_rf_addra        (is_rf_addra),
    .is_rf_addrb        (is_rf_addrb),
    .rf_is_dataa        (rf_is_dataa),
    .rf_is_datab        (rf_is_datab),
    .y_wb_regdest       (y_wb_regdest),
    .y_wb_writereg      (y_wb_writereg),
    .y_wb_wbvalue       (y_wb_wbvalue),
    .is_y_functionalunit(is_y_functionalunit),
    .is_y_rega          (is_y_rega),
    .is_y_regb          (is_y_regb),
    .is_y_regdest       (is_y_regdest)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  assign rf_is_dataa = rf[is_rf_addra];
  assign rf_is_datab = rf[is_rf_addrb];

  // ---------------- Execute_Y / register file model ----------------
  // Each stage holds one instruction; the last stage is what sits on y_wb_*,
  // and it is committed to the register file on the following edge.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      for (int k = 0; k <= L; k++) begin
        st_v[k] = 1'b0; st_rd[k] = 5'd0; st_val[k] = 32'd0; st_wr[k] = 1'b0;
      end
    end else begin
      if (st_v[L] && st_wr[L] && st_rd[L] != 5'd0) rf[st_rd[L]] = st_val[L];
      for (int k = L; k > 0; k--) begin
        st_v[k] = st_v[k-1]; st_rd[k] = st_rd[k-1];
        st_val[k] = st_val[k-1]; st_wr[k] = st_wr[k-1];
      end
      st_v[0]   = (is_y_functionalunit == 2'd3);
      st_rd[0]  = is_y_regdest;
      st_val[0] = is_y_rega * is_y_regb;
      st_wr[0]  = (wr_mode == 0) ? ($urandom_range(0, 7) != 0) : (wr_mode == 1);
    end
    y_wb_regdest  = st_rd[L];
    y_wb_wbvalue  = st_val[L];
    y_wb_writereg = st_v[L] && st_wr[L];
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] arch_value(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (st_v[L] && st_wr[L] && st_rd[L] == s) return st_val[L];
    return rf[s];
  endfunction

  function automatic logic pending_write(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    for (int k = 0; k < L; k++) begin
      if (st_v[k] && st_rd[k] == s) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      chk("reset_fu", 32'(is_y_functionalunit), 32'd0);
      chk("reset_ops", is_y_rega | is_y_regb | 32'(is_y_regdest), 32'd0);
      chk("reset_ready", 32'(dc_is_ready), 32'd1);
      exp_q.delete();
    end else begin
      if (is_y_functionalunit == 2'd3) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got rd=%0d expected no issue", is_y_regdest);
        end else begin
          e = exp_q.pop_front();
          chk("sb_regdest", 32'(is_y_regdest), 32'(e[68:64]));
          chk("sb_rega", is_y_rega, e[63:32]);
          chk("sb_regb", is_y_regb, e[31:0]);
        end
      end else begin
        chk("bubble_fu", 32'(is_y_functionalunit), 32'd0);
        chk("bubble_ops", is_y_rega | is_y_regb | 32'(is_y_regdest), 32'd0);
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_issue: got bubble expected %0d pending issue", exp_q.size());
          exp_q.delete();
        end
      end
      chk("ready", 32'(dc_is_ready),
          32'(!(pending_write(dc_is_rs) || pending_write(dc_is_rt))));
      if (dc_is_valid && !(pending_write(dc_is_rs) || pending_write(dc_is_rt)))
        exp_q.push_back({dc_is_rd, arch_value(dc_is_rs), arch_value(dc_is_rt)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       output int n_stall);
    n_stall = 0;
    dc_is_valid = 1'b1; dc_is_rs = s; dc_is_rt = t; dc_is_rd = d;
    forever begin
      @(negedge clock);
      if (dc_is_ready) break;
      n_stall++;
      if (n_stall > 40) begin
        checks++; errors++;
        $display("FAIL issue_timeout: got no ready after %0d cycles expected ready", n_stall);
        break;
      end
    end
    @(posedge clock); #1;
    dc_is_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    dc_is_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; dc_is_valid = 1'b0; dc_is_rs = 5'd0; dc_is_rt = 5'd0; dc_is_rd = 5'd0;
    y_wb_regdest = 5'd0; y_wb_writereg = 1'b0; y_wb_wbvalue = 32'd0; wr_mode = 1;
    rf[0] = 32'hDEADBEEF;
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    rf[1] = 32'd6; rf[2] = 32'd7;

    repeat (10) @(negedge clock);
    chk("reset_hold_fu", 32'(is_y_functionalunit), 32'd0);
    @(posedge clock); #1; reset = 1'b0;

    // single issue, then a bubble
    issue(5'd1, 5'd2, 5'd3, stalls);
    @(negedge clock);
    chk("single_fu", 32'(is_y_functionalunit), 32'd3);
    chk("single_rega", is_y_rega, 32'd6);
    chk("single_regb", is_y_regb, 32'd7);
    chk("single_rd", 32'(is_y_regdest), 32'd3);
    @(negedge clock);
    chk("after_fu", 32'(is_y_functionalunit), 32'd0);
    chk("after_ops", is_y_rega | is_y_regb | 32'(is_y_regdest), 32'd0);

    // RAW dependency resolved by forwarding
    idle(8); rf[3] = 32'd0;
    issue(5'd1, 5'd2, 5'd3, stalls);
    issue(5'd3, 5'd1, 5'd4, stalls);
    chk("raw_stalls", 32'(stalls), 32'd4);
    @(negedge clock);
    chk("raw_rega", is_y_rega, 32'd42);
    chk("raw_regb", is_y_regb, 32'd6);

    // overflowed producer: no write, register file value is used
    idle(8); rf[3] = 32'd99; wr_mode = 2;
    issue(5'd1, 5'd2, 5'd3, stalls);
    issue(5'd3, 5'd1, 5'd4, stalls);
    chk("ovf_stalls", 32'(stalls), 32'd4);
    @(negedge clock);
    chk("ovf_rega", is_y_rega, 32'd99);
    chk("ovf_regb", is_y_regb, 32'd6);
    idle(8); wr_mode = 1;

    // register zero never hazards and always reads zero
    issue(5'd1, 5'd2, 5'd0, stalls);
    issue(5'd2, 5'd1, 5'd0, stalls);
    issue(5'd1, 5'd1, 5'd0, stalls);
    issue(5'd0, 5'd0, 5'd5, stalls);
    chk("zero_stalls", 32'(stalls), 32'd0);
    @(negedge clock);
    chk("zero_rega", is_y_rega, 32'd0);
    chk("zero_regb", is_y_regb, 32'd0);

    // reset while a dependent instruction is stalled
    idle(8);
    issue(5'd1, 5'd2, 5'd5, stalls);
    issue(5'd2, 5'd1, 5'd7, stalls);
    dc_is_valid = 1'b1; dc_is_rs = 5'd5; dc_is_rt = 5'd7; dc_is_rd = 5'd6;
    #2 reset = 1'b1;
    #1;
    chk("midrst_fu", 32'(is_y_functionalunit), 32'd0);
    chk("midrst_ops", is_y_rega | is_y_regb | 32'(is_y_regdest), 32'd0);
    chk("midrst_ready", 32'(dc_is_ready), 32'd1);
    dc_is_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("postrst_ready", 32'(dc_is_ready), 32'd1);
    @(posedge clock); #1;
    issue(5'd5, 5'd7, 5'd6, stalls);
    chk("postrst_stalls", 32'(stalls), 32'd0);

    // random traffic with random overflow behaviour
    idle(8); wr_mode = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), stalls);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
